// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_pkg
// Description : Shared types and helpers for the bus generator arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_pkg;

  localparam int ID_W      = 8;
  localparam int PKT_MAX_W = 256;
  localparam int PORTS_MAX = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    PUSH = 2'd2
  } state_t;

  // Destination ID lives in the top ID_W bits of a pkt_w-wide packet.
  function automatic logic [ID_W-1:0] get_dst(input logic [PKT_MAX_W-1:0] pkt,
                                               input int                   pkt_w);
    return ID_W'(pkt >> (pkt_w - ID_W));
  endfunction

  // First requester at or above ptr, wrapping modulo n; -1 when nothing is requesting.
  function automatic int rr_next_grant(input logic [PORTS_MAX-1:0] req,
                                       input int                   ptr,
                                       input int                   n);
    int idx;
    rr_next_grant = -1;
    idx           = 0;
    for (int k = PORTS_MAX - 1; k >= 0; k--) begin
      if (k < n) begin
        idx = ptr + k;
        if (idx >= n) idx = idx - n;
        if (((req >> idx) & PORTS_MAX'(1)) != '0) rr_next_grant = idx;
      end
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/bus_lane_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bus_lane_arbiter
// Description : One bus lane: round-robin grant, pop the winner, push by dst.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_lane_arbiter
  import bus_pkg::*;
#(
  parameter int              DRVRS     = 4,
  parameter int              PCKG_SZ   = 16,
  parameter logic [ID_W-1:0] BROADCAST = 8'hFF
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [DRVRS-1:0]                pndng,
  input  logic [DRVRS-1:0][PCKG_SZ-1:0]   D_pop,
  output logic [DRVRS-1:0]                pop,
  output logic [DRVRS-1:0]                push,
  output logic [DRVRS-1:0][PCKG_SZ-1:0]   D_push
);

  localparam int PTR_W = (DRVRS > 1) ? $clog2(DRVRS) : 1;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [PTR_W-1:0]       r_ptr;
  logic [PTR_W-1:0]       w_ptr_nxt;
  logic [PTR_W-1:0]       r_src;
  logic [PTR_W-1:0]       w_src_nxt;
  logic [PCKG_SZ-1:0]     r_pkt;
  logic [PCKG_SZ-1:0]     w_pkt_nxt;
  logic [DRVRS-1:0]       r_pop;
  logic [DRVRS-1:0]       w_pop_nxt;
  logic [DRVRS-1:0]       r_push;
  logic [DRVRS-1:0]       w_push_nxt;

  int                     w_pick;
  logic [PCKG_SZ-1:0]     w_head;
  logic [ID_W-1:0]        w_dst;
  logic [DRVRS-1:0]       w_mask;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_src   <= '0;
      r_pkt   <= '0;
      r_pop   <= '0;
      r_push  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_src   <= w_src_nxt;
      r_pkt   <= w_pkt_nxt;
      r_pop   <= w_pop_nxt;
      r_push  <= w_push_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_src_nxt   = r_src;
    w_pkt_nxt   = r_pkt;
    w_pop_nxt   = '0;
    w_push_nxt  = '0;

    w_pick = rr_next_grant(PORTS_MAX'(pndng), int'(r_ptr), DRVRS);
    w_head = D_pop[r_src];
    w_dst  = get_dst(PKT_MAX_W'(w_head), PCKG_SZ);

    // Unknown destinations leave the mask empty so the packet is silently dropped.
    w_mask = '0;
    if (w_dst == BROADCAST) begin
      w_mask = ~(DRVRS'(1) << r_src);
    end else if (int'(w_dst) < DRVRS) begin
      w_mask = DRVRS'(1) << w_dst;
    end

    case (r_state)
      IDLE: begin
        if (w_pick >= 0) begin
          w_src_nxt   = PTR_W'(w_pick);
          w_pop_nxt   = DRVRS'(1) << w_pick;
          w_state_nxt = POP;
        end
      end
      POP: begin
        w_pkt_nxt   = w_head;
        w_push_nxt  = w_mask;
        w_state_nxt = PUSH;
      end
      PUSH: begin
        w_ptr_nxt   = (r_src == PTR_W'(DRVRS - 1)) ? '0 : r_src + 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign pop    = r_pop;
  assign push   = r_push;
  assign D_push = {DRVRS{r_pkt}};

endmodule
`default_nettype wire

// File: rtl/bus_generator_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bus_generator_arbiter
// Description : Multi-lane shared-bus packet switch; one arbiter per lane.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_generator_arbiter
  import bus_pkg::*;
#(
  parameter int              bits      = 1,
  parameter int              drvrs     = 4,
  parameter int              pckg_sz   = 16,
  parameter logic [ID_W-1:0] broadcast = 8'hFF
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [bits-1:0][drvrs-1:0]              pndng,
  input  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_pop,
  output logic [bits-1:0][drvrs-1:0]              pop,
  output logic [bits-1:0][drvrs-1:0]              push,
  output logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_push
);

  for (genvar g = 0; g < bits; g++) begin : g_lane
    bus_lane_arbiter #(
      .DRVRS     (drvrs),
      .PCKG_SZ   (pckg_sz),
      .BROADCAST (broadcast)
    ) u_lane (
      .clk    (clk),
      .reset  (reset),
      .pndng  (pndng[g]),
      .D_pop  (D_pop[g]),
      .pop    (pop[g]),
      .push   (push[g]),
      .D_push (D_push[g])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_bus_generator_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_generator_arbiter
// Description : Scoreboard bench: port FIFO model, pop/push monitors, scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_generator_arbiter;

  localparam int BITS  = 2;
  localparam int DRVRS = 4;
  localparam int PSZ   = 16;
  localparam int DEPTH = 8;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic [BITS-1:0][DRVRS-1:0]          pndng;
  logic [BITS-1:0][DRVRS-1:0]          pop;
  logic [BITS-1:0][DRVRS-1:0]          push;
  logic [BITS-1:0][DRVRS-1:0][PSZ-1:0] D_pop;
  logic [BITS-1:0][DRVRS-1:0][PSZ-1:0] D_push;

  typedef struct {
    int lane;
    int port;
    int cyc;
  } pop_ev_t;

  typedef struct {
    int               lane;
    logic [DRVRS-1:0] mask;
    logic [PSZ-1:0]   data;
    int               cyc;
  } push_ev_t;

  pop_ev_t  act_pop[$];
  push_ev_t act_push[$];
  push_ev_t exp_push[$];

  logic [PSZ-1:0] fmem [BITS][DRVRS][DEPTH];
  int fhead [BITS][DRVRS];
  int fcnt  [BITS][DRVRS];

  int cyc      = 0;
  int checks   = 0;
  int failures = 0;

  bus_generator_arbiter #(
    .bits      (BITS),
    .drvrs     (DRVRS),
    .pckg_sz   (PSZ),
    .broadcast (8'hFF)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .pndng  (pndng),
    .D_pop  (D_pop),
    .pop    (pop),
    .push   (push),
    .D_push (D_push)
  );

  always #5 clk = ~clk;

  task automatic refresh();
    for (int l = 0; l < BITS; l++)
      for (int p = 0; p < DRVRS; p++) begin
        pndng[l][p] = (fcnt[l][p] > 0);
        D_pop[l][p] = (fcnt[l][p] > 0) ? fmem[l][p][fhead[l][p]] : '0;
      end
  endtask

  task automatic send(input int l, input int p, input logic [PSZ-1:0] d);
    fmem[l][p][(fhead[l][p] + fcnt[l][p]) % DEPTH] = d;
    fcnt[l][p] = fcnt[l][p] + 1;
    refresh();
  endtask

  task automatic clear_all();
    for (int l = 0; l < BITS; l++)
      for (int p = 0; p < DRVRS; p++) begin
        fhead[l][p] = 0;
        fcnt[l][p]  = 0;
      end
    refresh();
    act_pop.delete();
    act_push.delete();
    exp_push.delete();
  endtask

  // One clock: FIFOs consume on the edge that ends a pop cycle, then monitors sample.
  task automatic tick();
    logic [BITS-1:0][DRVRS-1:0] pop_prev;
    pop_prev = pop;
    @(posedge clk);
    #1;
    cyc = cyc + 1;
    for (int l = 0; l < BITS; l++)
      for (int p = 0; p < DRVRS; p++)
        if (pop_prev[l][p] === 1'b1 && fcnt[l][p] > 0) begin
          fhead[l][p] = (fhead[l][p] + 1) % DEPTH;
          fcnt[l][p]  = fcnt[l][p] - 1;
        end
    refresh();
    for (int l = 0; l < BITS; l++) begin
      for (int p = 0; p < DRVRS; p++)
        if (pop[l][p] === 1'b1) act_pop.push_back('{l, p, cyc});
      if (push[l] !== '0) act_push.push_back('{l, push[l], D_push[l][0], cyc});
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    checks++;
    if (pop !== '0) begin failures++; $display("FAIL reset_pop got=%b want=0", pop); end
    checks++;
    if (push !== '0) begin failures++; $display("FAIL reset_push got=%b want=0", push); end
    checks++;
    if (D_push !== '0) begin failures++; $display("FAIL reset_dpush got=%h want=0", D_push); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_unicast();
    int c0;
    push_ev_t e, a;
    clear_all();
    send(0, 0, 16'h025A);
    exp_push.push_back('{0, 4'b0100, 16'h025A, 0});
    c0 = cyc;
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (act_pop.size() != 1) begin
      failures++; $display("FAIL uni_pop_count got=%0d want=1", act_pop.size());
    end else begin
      checks++;
      if (act_pop[0].lane != 0 || act_pop[0].port != 0 || act_pop[0].cyc != c0 + 1) begin
        failures++;
        $display("FAIL uni_pop got lane=%0d port=%0d cyc=%0d want lane=0 port=0 cyc=%0d",
                 act_pop[0].lane, act_pop[0].port, act_pop[0].cyc, c0 + 1);
      end
      checks++;
      if (act_push.size() < 1 || act_push[0].cyc != act_pop[0].cyc + 1) begin
        failures++; $display("FAIL uni_push_latency got pushes=%0d want push at cyc=%0d",
                             act_push.size(), act_pop[0].cyc + 1);
      end
    end
    while (exp_push.size() > 0) begin
      e = exp_push.pop_front();
      checks++;
      if (act_push.size() == 0) begin
        failures++; $display("FAIL uni_sb_missing got none want mask=%b data=%h", e.mask, e.data);
      end else begin
        a = act_push.pop_front();
        if (a.lane != e.lane || a.mask !== e.mask || a.data !== e.data) begin
          failures++;
          $display("FAIL uni_sb got lane=%0d mask=%b data=%h want lane=%0d mask=%b data=%h",
                   a.lane, a.mask, a.data, e.lane, e.mask, e.data);
        end
      end
    end
    checks++;
    if (act_push.size() != 0) begin failures++; $display("FAIL uni_sb_extra got=%0d want=0", act_push.size()); end
    checks++;
    if (D_push[0][2] !== 16'h025A) begin failures++; $display("FAIL uni_dpush_hold got=%h want=025a", D_push[0][2]); end
  endtask

  task automatic test_broadcast();
    push_ev_t e, a;
    clear_all();
    send(0, 1, 16'hFF33);
    exp_push.push_back('{0, 4'b1101, 16'hFF33, 0});
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (act_pop.size() != 1 || act_pop[0].port != 1) begin
      failures++; $display("FAIL bc_pop got count=%0d want one pop of port 1", act_pop.size());
    end
    while (exp_push.size() > 0) begin
      e = exp_push.pop_front();
      checks++;
      if (act_push.size() == 0) begin
        failures++; $display("FAIL bc_sb_missing got none want mask=%b data=%h", e.mask, e.data);
      end else begin
        a = act_push.pop_front();
        if (a.lane != e.lane || a.mask !== e.mask || a.data !== e.data) begin
          failures++;
          $display("FAIL bc_sb got lane=%0d mask=%b data=%h want lane=%0d mask=%b data=%h",
                   a.lane, a.mask, a.data, e.lane, e.mask, e.data);
        end
      end
    end
    checks++;
    if (act_push.size() != 0) begin failures++; $display("FAIL bc_sb_extra got=%0d want=0", act_push.size()); end
    for (int p = 0; p < DRVRS; p++) begin
      checks++;
      if (D_push[0][p] !== 16'hFF33) begin
        failures++; $display("FAIL bc_dpush port=%0d got=%h want=ff33", p, D_push[0][p]);
      end
    end
  endtask

  task automatic test_round_robin();
    push_ev_t e, a;
    clear_all();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      send(0, 0, 16'(16'h01A0 + i));
      send(0, 3, 16'(16'h02B0 + i));
      exp_push.push_back('{0, 4'b0010, 16'(16'h01A0 + i), 0});
      exp_push.push_back('{0, 4'b0100, 16'(16'h02B0 + i), 0});
    end
    for (int i = 0; i < 30; i++) tick();
    checks++;
    if (act_pop.size() != 8) begin
      failures++; $display("FAIL rr_pop_count got=%0d want=8", act_pop.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (act_pop[i].port != ((i % 2 == 0) ? 0 : 3)) begin
          failures++; $display("FAIL rr_order idx=%0d got port=%0d want=%0d", i, act_pop[i].port, (i % 2 == 0) ? 0 : 3);
        end
        if (i > 0) begin
          checks++;
          if (act_pop[i].cyc - act_pop[i-1].cyc != 3) begin
            failures++; $display("FAIL rr_spacing idx=%0d got=%0d want=3", i, act_pop[i].cyc - act_pop[i-1].cyc);
          end
        end
      end
    end
    while (exp_push.size() > 0) begin
      e = exp_push.pop_front();
      checks++;
      if (act_push.size() == 0) begin
        failures++; $display("FAIL rr_sb_missing got none want mask=%b data=%h", e.mask, e.data);
      end else begin
        a = act_push.pop_front();
        if (a.lane != e.lane || a.mask !== e.mask || a.data !== e.data) begin
          failures++;
          $display("FAIL rr_sb got lane=%0d mask=%b data=%h want lane=%0d mask=%b data=%h",
                   a.lane, a.mask, a.data, e.lane, e.mask, e.data);
        end
      end
    end
    checks++;
    if (act_push.size() != 0) begin failures++; $display("FAIL rr_sb_extra got=%0d want=0", act_push.size()); end
  endtask

  task automatic test_invalid_dest();
    push_ev_t e, a;
    clear_all();
    send(0, 2, 16'h0711);
    send(0, 3, 16'h0155);
    exp_push.push_back('{0, 4'b0010, 16'h0155, 0});
    for (int i = 0; i < 9; i++) tick();
    checks++;
    if (act_pop.size() != 2 || act_pop[0].port != 2 || act_pop[1].port != 3) begin
      failures++; $display("FAIL inv_pops got count=%0d want ports 2 then 3", act_pop.size());
    end else begin
      checks++;
      if (act_pop[1].cyc - act_pop[0].cyc != 3) begin
        failures++; $display("FAIL inv_spacing got=%0d want=3", act_pop[1].cyc - act_pop[0].cyc);
      end
      checks++;
      if (act_push.size() < 1 || act_push[0].cyc != act_pop[1].cyc + 1) begin
        failures++; $display("FAIL inv_push_timing got pushes=%0d want first push at cyc=%0d",
                             act_push.size(), act_pop[1].cyc + 1);
      end
    end
    while (exp_push.size() > 0) begin
      e = exp_push.pop_front();
      checks++;
      if (act_push.size() == 0) begin
        failures++; $display("FAIL inv_sb_missing got none want mask=%b data=%h", e.mask, e.data);
      end else begin
        a = act_push.pop_front();
        if (a.lane != e.lane || a.mask !== e.mask || a.data !== e.data) begin
          failures++;
          $display("FAIL inv_sb got lane=%0d mask=%b data=%h want lane=%0d mask=%b data=%h",
                   a.lane, a.mask, a.data, e.lane, e.mask, e.data);
        end
      end
    end
    checks++;
    if (act_push.size() != 0) begin failures++; $display("FAIL inv_sb_extra got=%0d want=0", act_push.size()); end
  endtask

  task automatic test_reset_mid_transfer();
    bit found;
    push_ev_t e, a;
    clear_all();
    send(0, 1, 16'h0077);
    exp_push.push_back('{0, 4'b0001, 16'h0077, 0});
    for (int i = 0; i < 6; i++) tick();
    send(0, 2, 16'h0011);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (pop[0][2] === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found) begin failures++; $display("FAIL mid_pop_wait got no pop of port 2 want one within 10 cycles"); end
    reset = 1'b0;
    tick();
    checks++;
    if (pop !== '0) begin failures++; $display("FAIL mid_pop got=%b want=0", pop); end
    checks++;
    if (push !== '0) begin failures++; $display("FAIL mid_push got=%b want=0", push); end
    checks++;
    if (D_push !== '0) begin failures++; $display("FAIL mid_dpush got=%h want=0", D_push); end
    reset = 1'b1;
    tick();
    send(0, 0, 16'h0322);
    send(0, 3, 16'h0144);
    exp_push.push_back('{0, 4'b1000, 16'h0322, 0});
    exp_push.push_back('{0, 4'b0010, 16'h0144, 0});
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (act_pop.size() != 4 || act_pop[2].port != 0 || act_pop[3].port != 3) begin
      failures++; $display("FAIL mid_priority got pops=%0d want ports 1,2,0,3", act_pop.size());
    end
    while (exp_push.size() > 0) begin
      e = exp_push.pop_front();
      checks++;
      if (act_push.size() == 0) begin
        failures++; $display("FAIL mid_sb_missing got none want mask=%b data=%h", e.mask, e.data);
      end else begin
        a = act_push.pop_front();
        if (a.lane != e.lane || a.mask !== e.mask || a.data !== e.data) begin
          failures++;
          $display("FAIL mid_sb got lane=%0d mask=%b data=%h want lane=%0d mask=%b data=%h",
                   a.lane, a.mask, a.data, e.lane, e.mask, e.data);
        end
      end
    end
    checks++;
    if (act_push.size() != 0) begin failures++; $display("FAIL mid_sb_extra got=%0d want=0", act_push.size()); end
  endtask

  task automatic test_self_address();
    push_ev_t e, a;
    clear_all();
    send(0, 3, 16'h03C4);
    send(1, 0, 16'hFF5E);
    exp_push.push_back('{0, 4'b1000, 16'h03C4, 0});
    exp_push.push_back('{1, 4'b1110, 16'hFF5E, 0});
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (act_push.size() != 2 || act_push[0].cyc != act_push[1].cyc) begin
      failures++; $display("FAIL self_concurrent got pushes=%0d want two in the same cycle", act_push.size());
    end
    while (exp_push.size() > 0) begin
      e = exp_push.pop_front();
      checks++;
      if (act_push.size() == 0) begin
        failures++; $display("FAIL self_sb_missing got none want mask=%b data=%h", e.mask, e.data);
      end else begin
        a = act_push.pop_front();
        if (a.lane != e.lane || a.mask !== e.mask || a.data !== e.data) begin
          failures++;
          $display("FAIL self_sb got lane=%0d mask=%b data=%h want lane=%0d mask=%b data=%h",
                   a.lane, a.mask, a.data, e.lane, e.mask, e.data);
        end
      end
    end
    checks++;
    if (act_push.size() != 0) begin failures++; $display("FAIL self_sb_extra got=%0d want=0", act_push.size()); end
    checks++;
    if (D_push[0][3] !== 16'h03C4) begin failures++; $display("FAIL self_dpush got=%h want=03c4", D_push[0][3]); end
  endtask

  initial begin
    clear_all();
    test_reset();
    test_unicast();
    test_broadcast();
    test_round_robin();
    test_invalid_dest();
    test_reset_mid_transfer();
    test_self_address();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bus_generator_arbiter.md
# bus_generator_arbiter

Shared-bus packet switch with a round-robin arbiter, serving `drvrs` FIFO-style driver ports on each of `bits` independent buses. Per bus it pops one pending packet from a port and pushes it to the port named in the packet's destination field, or to all other ports for the broadcast ID. It sits between the per-port driver/monitor FIFOs (through `bus_if`) and is the DUT of the bus-level environment (agent → driver → DUT → monitor → checker).

## Interface
- `bits`, default 1: number of independent buses/lanes.
- `drvrs`, default 4: ports per bus.
- `pckg_sz`, default 16: packet width; bits [pckg_sz-1 -: 8] hold the destination ID.
- `broadcast`, default 8'hFF: destination ID meaning "all ports except the source".

Ports (all arrays are packed as [bits-1:0][drvrs-1:0]; data arrays add [pckg_sz-1:0]):
- `clk`  in  1: the single clock; all logic on its rising edge.
- `reset`  in  1: synchronous, active-low reset.
- `pndng`  in  bits×drvrs: port FIFO holds at least one packet.
- `D_pop`  in  bits×drvrs×pckg_sz: head-of-FIFO data. Valid whenever the matching `pndng` is 1 (show-ahead).
- `pop`  out  bits×drvrs: one-cycle strobe that consumes the FIFO head.
- `push`  out  bits×drvrs: one-cycle strobe that delivers `D_push` to the port.
- `D_push`  out  bits×drvrs×pckg_sz: delivered packet. The same value is driven to every port of a bus.

## Operation
- Each bus runs its own FSM, and buses operate concurrently and independently. States:
  - IDLE: if any `pndng` is set, grant the first set port found scanning upward from `ptr`, wrapping modulo drvrs. Latch the port as `src` and go to POP. Otherwise stay in IDLE.
  - POP: assert `pop[src]`, latch `pkt = D_pop[src]` and go to PUSH.
  - PUSH: drive `D_push = pkt` on all ports and assert the push strobe(s), then set `ptr = (src+1) mod drvrs` and go to IDLE.
- Destination decode uses `dst = pkt[pckg_sz-1 -: 8]`:
  - `dst == broadcast`: push to every port except `src`.
  - `dst < drvrs`: push to port `dst` only. If `dst == src`, the packet is delivered back to `src`.
  - Any other value: the packet is dropped. No push occurs, but the FSM still passes through PUSH.
- A port that drops `pndng` before its grant is skipped. `pndng` is sampled only in IDLE.
- Arithmetic: `ptr` is $clog2(drvrs) bits wide (minimum 1) and wraps at drvrs, not at a power of two.

## Timing
- One transfer every 3 cycles per bus: grant (IDLE) → `pop` (cycle +1) → `push` (cycle +2). The next IDLE decision is at cycle +3.
- `pop` and `push` are registered and high for exactly one cycle per transfer.
- `D_push` holds the last delivered packet until the next PUSH.
- Reset (`reset == 0` at a clock edge) forces, from the next cycle on: `push = 0`, `pop = 0`, `D_push = 0`, `ptr = 0`, state IDLE, `pkt = 0`. This applies in any state.
- If reset is applied mid-transfer (in POP or PUSH), the transfer is abandoned. No strobe is emitted after the reset edge.
- With continuous `pndng` on all ports, service order is 0, 1, …, drvrs-1, 0, ….

## Structure
- Package `bus_pkg`:
  - `ID_W = 8` constant.
  - State enum {IDLE, POP, PUSH}.
  - Function `get_dst(pkt)`.
  - Round-robin next-grant function.
- Sub-module `bus_lane_arbiter` implements one bus (FSM, `ptr`, `pkt`, decode). The top instantiates it `bits` times in a generate loop and only maps port slices.

## Test plan
- Unicast: port 0 `pndng = 1` with `D_pop = 16'h025A`. Required response: `pop[0]` one cycle later, then `push[2]` with `D_push = 16'h025A`. No other `push` bit rises.
- Broadcast: port 1 sends `16'hFF33`. Required response: `push[0]`, `push[2]` and `push[3]` are high in the same cycle, `push[1]` stays 0, and `D_push = 16'hFF33`.
- Round-robin: ports 0 and 3 pending continuously. Required response: pops alternate 0, 3, 0, 3, spaced 3 cycles apart.
- Invalid destination: port 2 sends `16'h0711`. Required response: `pop[2]` is asserted and no `push` follows. The next pending port is served 3 cycles after the grant.
- Reset mid-transfer: drive `reset = 0` in the POP cycle. Required response: all outputs are 0 on the next cycle, no `push` occurs, and after release port 0 has priority (`ptr = 0`).
- Self-address: port 3 sends `16'h03C4`. Required response: `push[3]` with `D_push = 16'h03C4`.
